intr_controller: RTL and testbench
==================================

Name: intr_controller

Overview:
- Memory-mapped interrupt controller that sits directly downstream of Timer16 and sibling peripherals.
- Consumes their sigIntr lines as sources and latches, masks and prioritises them.
- Presents one interrupt request and a source ID to the processor.
- Shares Timer16's 4-register, 16-bit tri-state bus protocol so both decode off the same busAddr/busData/busEn/busWr wiring.

Parameters:
- NUM_SRC, 8, number of interrupt sources (legal 1..16); source 0 is highest priority.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- busAddr  input  2  register select.
- busData  inout  16  bidirectional data; driven only during reads, otherwise high-Z.
- busEn  input  1  bus access strobe.
- busWr  input  1  1 = write, 0 = read (valid with busEn).
- srcIntr  input  NUM_SRC  peripheral interrupt lines (e.g. Timer16 sigIntr on bit 0); same clock domain as clk.
- sigIntr  output  1  registered interrupt request to processor.
- intrId  output  4  registered index of highest-priority active source.

Behaviour:
- Register map:
  - addr 0 PEND: read pending[NUM_SRC-1:0]; write-1-to-clear for edge sources.
  - addr 1 MASK: RW, 1 = source enabled.
  - addr 2 EDGE: RW, 1 = rising-edge mode, 0 = level mode.
  - addr 3 CTRL read: {sigIntr, 10'b0, gen, intrId}. CTRL write: bit0 -> gen (global enable); bit1 = 1 acknowledges the current intrId (clears its pending bit if edge mode and sigIntr = 1).
- Bits at or above NUM_SRC read 0; writes to them are ignored.
- Reads:
  - When busEn & ~busWr, busData is driven combinationally from the selected register in the same cycle.
  - No register side effects on read.
- Writes: take effect on the clk edge where busEn & busWr are high.
- Reset (rst high at an edge):
  - pending = 0, mask = 0, edge = all 1s, gen = 0.
  - srcPrev = all 1s, so a source already high at release makes no spurious edge.
  - sigIntr = 0, intrId = 0.
  - busData = high-Z.
  - Reset overrides any bus write in the same cycle.
- srcPrev register: samples srcIntr every cycle.
- Edge-mode source i:
  - pending[i] is set when srcIntr[i] & ~srcPrev[i].
  - It holds until cleared by a PEND write-1 or a CTRL ack.
  - If set and clear occur in the same cycle, set wins and pending stays 1.
- Level-mode source i:
  - pending[i] <= srcIntr[i] every cycle (one-cycle registered copy).
  - PEND write-1 and ack have no effect.
- Switching EDGE for a source: its pending bit follows the new mode's rule from the next edge; no clear is implied.
- active = pending & mask.
- sigIntr <= gen & |active, registered.
- intrId <= lowest index i with active[i] set, or 0 if none, registered.
- Latency:
  - srcIntr rises before edge N, so pending is set at edge N.
  - sigIntr/intrId update at edge N+1.
  - Mask, gen and clear writes affect sigIntr one edge after the write edge.
- Ack behaviour:
  - Acknowledge uses the registered intrId value present during the write cycle.
  - Ack with sigIntr = 0 is a no-op.
- Back-to-back pending sources: after an ack clears the top source, the next lowest index appears on intrId one cycle after the pending clear.

Test Plan:
- Reset, then read all four addresses -> PEND 0x0000, MASK 0x0000, EDGE 0x00FF, CTRL 0x0000; busData high-Z when busEn = 0.
- MASK = 0x0001, CTRL = 0x0001, pulse srcIntr[0] for 1 cycle -> PEND bit0 = 1 at the next edge, sigIntr = 1 and intrId = 0 one edge later; CTRL write 0x0003 -> PEND 0, sigIntr = 0 two edges after the write.
- MASK = 0x00FF, gen = 1, pulse srcIntr[5] and srcIntr[2] together -> intrId = 2; ack -> intrId = 5, sigIntr stays 1; ack -> sigIntr = 0.
- Edge source 3: a new rising edge in the same cycle as a PEND write 0x0008 -> PEND bit3 remains 1.
- EDGE = 0x0000, MASK = 0x0010, gen = 1, hold srcIntr[4] high -> sigIntr = 1 persists despite PEND write 0x0010; drop srcIntr[4] -> sigIntr = 0 two edges later.
- srcIntr[1] pending with mask set, assert rst mid-operation -> all registers return to reset values the next edge; srcIntr[1] held high through release causes no new pending.

Source files
------------

// File: rtl/intr_controller.sv
// Interrupt controller: latches, masks and prioritises NUM_SRC peripheral
// interrupt lines and presents one registered request plus source ID.
// It shares the 4-register, 16-bit tri-state bus protocol used by Timer16.

// Per-source pending latch with edge/level capture.
module intr_lane (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_mode,
  input  logic clr,
  output logic pending
);
  logic src_prev;

  // src_prev resets high so a line already asserted at release makes no edge.
  // In edge mode a new rising edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_prev <= 1'b1;
      pending  <= 1'b0;
    end else begin
      src_prev <= src;
      if (edge_mode) pending <= (src & ~src_prev) | (pending & ~clr);
      else           pending <= src;
    end
  end
endmodule

module intr_controller #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         busAddr,
  inout  wire  [15:0]        busData,
  input  logic               busEn,
  input  logic               busWr,
  input  logic [NUM_SRC-1:0] srcIntr,
  output logic               sigIntr,
  output logic [3:0]         intrId
);
  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_EDGE = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  logic [NUM_SRC-1:0] pending, mask, edge_sel, active, clr;
  logic               gen, sig_q;
  logic [3:0]         id_q, id_nxt;
  logic [15:0]        rd_data, wdata;
  logic               wr, rd;

  assign wr    = busEn & busWr;
  assign rd    = busEn & ~busWr;
  assign wdata = busData;

  // Only low NUM_SRC bits matter for most registers; fold the rest away.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // Clear requests: PEND write-1, or an ack naming the currently reported
  // source while a request is actually up. Level lanes ignore clr.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr[i] = (wr && busAddr == A_PEND && wdata[i]) ||
               (wr && busAddr == A_CTRL && wdata[1] && sig_q && id_q == 4'(i));
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_lane
      intr_lane u_lane (
        .clk       (clk),
        .rst       (rst),
        .src       (srcIntr[g]),
        .edge_mode (edge_sel[g]),
        .clr       (clr[g]),
        .pending   (pending[g])
      );
    end
  endgenerate

  assign active = pending & mask;

  // Lowest active index wins; 0 when nothing is active.
  always_comb begin
    id_nxt = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) id_nxt = 4'(i);
    end
  end

  // Config registers and the registered request/ID; reset beats bus writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask     <= '0;
      edge_sel <= '1;
      gen      <= 1'b0;
      sig_q    <= 1'b0;
      id_q     <= '0;
    end else begin
      if (wr) begin
        case (busAddr)
          A_MASK:  mask     <= wdata[NUM_SRC-1:0];
          A_EDGE:  edge_sel <= wdata[NUM_SRC-1:0];
          A_CTRL:  gen      <= wdata[0];
          default: ;
        endcase
      end
      sig_q <= gen & (|active);
      id_q  <= id_nxt;
    end
  end

  // Combinational read mux; bits at or above NUM_SRC read as zero.
  always_comb begin
    rd_data = '0;
    case (busAddr)
      A_PEND:  rd_data[NUM_SRC-1:0] = pending;
      A_MASK:  rd_data[NUM_SRC-1:0] = mask;
      A_EDGE:  rd_data[NUM_SRC-1:0] = edge_sel;
      default: rd_data = {sig_q, 10'b0, gen, id_q};
    endcase
  end

  assign busData = rd ? rd_data : 16'hzzzz;
  assign sigIntr = sig_q;
  assign intrId  = id_q;
endmodule

// File: tb/tb_intr_controller.sv
// Directed bench for intr_controller with a behavioural reference model.
module tb_intr_controller;
  localparam int N = 8;
  localparam logic [15:0] NMASK = 16'h00FF;

  logic         clk, rst, busEn, busWr;
  logic [1:0]   busAddr;
  logic [15:0]  tb_data;
  wire  [15:0]  busData;
  logic [N-1:0] srcIntr;
  wire          sigIntr;
  wire  [3:0]   intrId;

  int checks = 0;
  int failures = 0;

  assign busData = (busEn && busWr) ? tb_data : 16'hzzzz;

  intr_controller #(.NUM_SRC(N)) dut (
    .clk(clk), .rst(rst), .busAddr(busAddr), .busData(busData),
    .busEn(busEn), .busWr(busWr), .srcIntr(srcIntr),
    .sigIntr(sigIntr), .intrId(intrId)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: pending/mask/edge as plain bit vectors, updated from the
  // inputs seen at each rising edge.
  bit [15:0] m_pend, m_mask, m_edge, m_prev, m_clr, m_act, m_np;
  bit        m_gen, m_sig, m_ok = 0;
  int        m_id, m_first;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0; m_mask = 0; m_edge = NMASK; m_prev = NMASK;
      m_gen = 0; m_sig = 0; m_id = 0; m_ok = 1;
    end else begin
      m_clr = 0;
      if (busEn && busWr && busAddr == 2'd0) m_clr = tb_data & NMASK;
      if (busEn && busWr && busAddr == 2'd3 && tb_data[1] && m_sig) m_clr[m_id] = 1'b1;
      m_act = m_pend & m_mask;
      m_first = 0;
      for (int i = N - 1; i >= 0; i--) if (m_act[i]) m_first = i;
      m_np = 0;
      for (int i = 0; i < N; i++)
        m_np[i] = m_edge[i] ? ((srcIntr[i] && !m_prev[i]) || (m_pend[i] && !m_clr[i]))
                            : srcIntr[i];
      m_sig  = m_gen && (m_act != 0);
      m_id   = m_first;
      m_pend = m_np;
      m_prev = {8'h00, srcIntr};
      if (busEn && busWr) begin
        case (busAddr)
          2'd1: m_mask = tb_data & NMASK;
          2'd2: m_edge = tb_data & NMASK;
          2'd3: m_gen  = tb_data[0];
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison of the registered outputs against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("sigIntr_model", {31'b0, sigIntr}, {31'b0, m_sig});
      chk("intrId_model", {28'b0, intrId}, m_id);
    end
  end

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    busEn = 1; busWr = 1; busAddr = a; tb_data = d;
    @(negedge clk);
    busEn = 0; busWr = 0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string nm);
    busEn = 1; busWr = 0; busAddr = a;
    #1;
    chk(nm, {16'b0, busData}, {16'b0, exp});
    busEn = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; busEn = 0; busWr = 0; busAddr = 0; tb_data = 0; srcIntr = 0;
    cyc(2);
    rst = 0;

    // Reset values
    rd(2'd0, 16'h0000, "rst_pend");
    rd(2'd1, 16'h0000, "rst_mask");
    rd(2'd2, 16'h00FF, "rst_edge");
    rd(2'd3, 16'h0000, "rst_ctrl");

    // Single edge source 0, then ack
    wr(2'd1, 16'h0001);
    wr(2'd3, 16'h0001);
    srcIntr[0] = 1; cyc(1); srcIntr[0] = 0;
    rd(2'd0, 16'h0001, "pend0_set");
    chk("sig_not_yet", {31'b0, sigIntr}, 0);
    cyc(1);
    chk("sig_src0", {31'b0, sigIntr}, 1);
    chk("id_src0", {28'b0, intrId}, 0);
    rd(2'd3, 16'h8010, "ctrl_active");
    wr(2'd3, 16'h0003);
    rd(2'd0, 16'h0000, "pend0_acked");
    chk("sig_ack_edge", {31'b0, sigIntr}, 1);
    cyc(1);
    chk("sig_after_ack", {31'b0, sigIntr}, 0);

    // Two simultaneous sources: priority then back-to-back acks
    wr(2'd1, 16'h00FF);
    srcIntr = 8'h24; cyc(1); srcIntr = 0; cyc(1);
    chk("id_prio2", {28'b0, intrId}, 2);
    chk("sig_prio", {31'b0, sigIntr}, 1);
    wr(2'd3, 16'h0003);
    chk("id_still2", {28'b0, intrId}, 2);
    cyc(1);
    chk("id_next5", {28'b0, intrId}, 5);
    chk("sig_stays", {31'b0, sigIntr}, 1);
    wr(2'd3, 16'h0003);
    cyc(1);
    chk("sig_all_acked", {31'b0, sigIntr}, 0);

    // Edge set beats same-cycle PEND clear
    srcIntr[3] = 1; cyc(1); srcIntr[3] = 0; cyc(1);
    srcIntr[3] = 1;
    wr(2'd0, 16'h0008);
    srcIntr[3] = 0;
    rd(2'd0, 16'h0008, "set_wins");
    wr(2'd0, 16'h0008);
    rd(2'd0, 16'h0000, "pend3_cleared");
    cyc(1);

    // Level mode: PEND write has no effect; drop follows the line
    wr(2'd2, 16'h0000);
    wr(2'd1, 16'hFF10);
    rd(2'd1, 16'h0010, "mask_upper_ignored");
    srcIntr[4] = 1; cyc(2);
    chk("lvl_sig", {31'b0, sigIntr}, 1);
    chk("lvl_id", {28'b0, intrId}, 4);
    wr(2'd0, 16'h0010);
    cyc(1);
    chk("lvl_no_clear", {31'b0, sigIntr}, 1);
    rd(2'd0, 16'h0010, "lvl_pend");
    srcIntr[4] = 0; cyc(1);
    chk("lvl_drop_hold", {31'b0, sigIntr}, 1);
    cyc(1);
    chk("lvl_drop", {31'b0, sigIntr}, 0);

    // Reset mid-operation, with a competing write and source 1 held high
    wr(2'd2, 16'h00FF);
    wr(2'd1, 16'h0002);
    srcIntr[1] = 1; cyc(2);
    chk("pre_rst_sig", {31'b0, sigIntr}, 1);
    chk("pre_rst_id", {28'b0, intrId}, 1);
    rst = 1; busEn = 1; busWr = 1; busAddr = 2'd1; tb_data = 16'hFFFF;
    cyc(1);
    rst = 0; busEn = 0; busWr = 0;
    rd(2'd0, 16'h0000, "rst2_pend");
    rd(2'd1, 16'h0000, "rst2_mask");
    rd(2'd2, 16'h00FF, "rst2_edge");
    rd(2'd3, 16'h0000, "rst2_ctrl");
    cyc(3);
    rd(2'd0, 16'h0000, "no_spurious_edge");
    chk("rst2_sig", {31'b0, sigIntr}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
